// File: rtl/ray_dir_gen.sv
// ray_dir_gen: per-frame raster-order primary-ray direction generator with valid/ready output.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start                one-cycle frame start (ignored while busy or during o_frame_done)
//   i_ready                downstream accepts the current word
//   o_valid                output word valid
//   o_dir_x/y/z            camera-space ray direction, FP27 (sign, 8-bit exp bias 127, 18-bit mantissa)
//   o_pix_x, o_pix_y       pixel coordinates of the current word
//   o_last                 current word is the final pixel of the frame
//   o_busy                 frame in progress
//   o_frame_done           one-cycle pulse after the last word is accepted
module ray_dir_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int SCALE_SHIFT = 8,
    parameter logic [26:0] FOCAL_FP = 27'h1FC0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [26:0]              o_dir_x,
    output logic [26:0]              o_dir_y,
    output logic [26:0]              o_dir_z,
    output logic [$clog2(H_RES)-1:0] o_pix_x,
    output logic [$clog2(V_RES)-1:0] o_pix_y,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_frame_done
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    typedef enum logic {IDLE, GEN} state_t;

    state_t state, state_n;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic hs, done, load, start_ok, x_end, y_end;
    int dx, dy;

    // Exact int-to-FP27: priority-encode the MSB, then shift the remaining bits up to the mantissa top.
    function automatic logic [26:0] to_fp(input int d);
        logic [31:0] a;
        logic [63:0] t;
        int m;
        a = (d < 0) ? 32'(-d) : 32'(d);
        m = 0;
        for (int i = 0; i < 32; i++)
            if (a[i]) m = i;
        t = {32'd0, a} << (32 - m);
        return (d == 0) ? 27'd0 : {d < 0, 8'(127 + m - SCALE_SHIFT), t[31:14]};
    endfunction

    always_comb begin
        hs = o_valid && i_ready;
        done = (state == GEN) && hs && o_last;
        load = (state == GEN) && (!o_valid || i_ready) && !done;
        // A start landing in the frame-done cycle belongs to the frame that just ended.
        start_ok = (state == IDLE) && i_start && !o_frame_done;
        state_n = start_ok ? GEN : done ? IDLE : state;
        x_end = (cx == XW'(H_RES - 1));
        y_end = (cy == YW'(V_RES - 1));
        dx = int'(cx) - H_RES / 2;
        dy = V_RES / 2 - int'(cy);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cx <= '0;
            cy <= '0;
            o_valid <= 1'b0;
            o_dir_x <= '0;
            o_dir_y <= '0;
            o_pix_x <= '0;
            o_pix_y <= '0;
            o_last <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state <= state_n;
            o_frame_done <= done;
            if (start_ok) begin
                cx <= '0;
                cy <= '0;
            end
            if (load) begin
                o_valid <= 1'b1;
                o_dir_x <= to_fp(dx);
                o_dir_y <= to_fp(dy);
                o_pix_x <= cx;
                o_pix_y <= cy;
                o_last <= x_end && y_end;
                cx <= x_end ? '0 : cx + XW'(1);
                cy <= x_end ? (y_end ? '0 : cy + YW'(1)) : cy;
            end
            if (done) o_valid <= 1'b0;
        end
    end

    assign o_busy = (state == GEN);
    assign o_dir_z = FOCAL_FP;
endmodule
